noc_credit_sched: RTL

- Credit-based scheduler between the root of the multiplier-to-adder NoC arbitration tree and the adder-side demux tree.
- Takes the single root packet stream and keeps a per-adder credit counter. It issues one-hot valid strobes to the adders.
- Raises stall into the root arbiter's busy input when the target adder has no free slot, or when a flush is draining the network.

---
 rtl/noc_credit_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/noc_credit_sched.sv
// noc_credit_sched: credit-based issue stage between the NoC root
// arbiter and the adder-side demux tree.
module noc_credit_sched #(
  parameter int bit_width  = 16,
  parameter int log_n_add  = 6,
  parameter int ctrl_bit   = 1,
  parameter int max_credit = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [bit_width+log_n_add+ctrl_bit-1:0] in_pkt,
  input  logic [2**log_n_add-1:0]               credit_ret,
  input  logic                                  flush,
  output logic                                  stall,
  output logic [bit_width-1:0]                  out_data,
  output logic [2**log_n_add-1:0]               out_val,
  output logic                                  flush_done,
  output logic                                  idle,
  output logic                                  cred_err
);

  localparam int n_add = 2**log_n_add;
  localparam int pkt_w = bit_width + log_n_add + ctrl_bit;
  localparam logic [1:0] cmax = 2'(max_credit);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    HOLD,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic                 pkt_vld;
  logic [log_n_add-1:0] pkt_addr;
  logic [bit_width-1:0] pkt_data;

  logic [1:0]           credit    [n_add];
  logic [1:0]           credit_nx [n_add];
  logic [n_add-1:0]     err_vec;
  logic [n_add-1:0]     iss_vec;

  logic                 hold_vld;
  logic [log_n_add-1:0] hold_addr;
  logic [bit_width-1:0] hold_data;
  logic                 flush_lat;

  logic [log_n_add-1:0] sel_addr;
  logic [bit_width-1:0] sel_data;
  logic                 can_iss;
  logic                 run_acc;
  logic                 issue;
  logic                 capture;
  logic                 all_full;
  logic                 all_full_nx;
  logic                 lat_nx;
  logic                 done_nx;

  assign pkt_vld  = in_pkt[pkt_w-1];
  assign pkt_addr = in_pkt[bit_width +: log_n_add];
  assign pkt_data = in_pkt[bit_width-1:0];

  // Stall and idle decode registered state only.
  assign stall = (state != RUN);
  assign idle  = (state == RUN) && !hold_vld && all_full;

  // Issue decision for the packet at the head: held word or live input.
  always_comb begin
    sel_addr = (state == HOLD) ? hold_addr : pkt_addr;
    sel_data = (state == HOLD) ? hold_data : pkt_data;
    can_iss  = (credit[sel_addr] != 2'd0) || credit_ret[sel_addr];
    run_acc  = (state == RUN) && pkt_vld;
    issue    = (run_acc || (state == HOLD)) && can_iss;
    capture  = run_acc && !can_iss;
    iss_vec  = '0;
    iss_vec[sel_addr] = issue;
  end

  // Per-adder credit arithmetic; a return into a full counter saturates.
  always_comb begin
    all_full    = 1'b1;
    all_full_nx = 1'b1;
    for (int k = 0; k < n_add; k++) begin
      credit_nx[k] = credit[k];
      err_vec[k]   = 1'b0;
      unique case (1'b1)
        credit_ret[k] & ~iss_vec[k]: begin
          if (credit[k] == cmax) begin
            err_vec[k] = 1'b1;
          end else begin
            credit_nx[k] = credit[k] + 2'd1;
          end
        end
        iss_vec[k] & ~credit_ret[k]: begin
          credit_nx[k] = credit[k] - 2'd1;
        end
        default: begin
          credit_nx[k] = credit[k];
        end
      endcase
      all_full    = all_full & (credit[k] == cmax);
      all_full_nx = all_full_nx & (credit_nx[k] == cmax);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; an accepted packet is serviced before a flush.
  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: state_nx = RUN;
      RUN: begin
        if (capture) begin
          state_nx = HOLD;
        end else if (flush) begin
          state_nx = DRAIN;
        end
      end
      HOLD: begin
        if (can_iss) begin
          state_nx = (flush_lat || flush) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if ((!flush_lat || all_full_nx) && !flush) begin
          state_nx = RUN;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  // Output/control decode: flush latch and single drain-done pulse.
  always_comb begin
    done_nx = (state == DRAIN) && flush_lat && all_full_nx;
    lat_nx  = flush_lat;
    if (((state == RUN) || (state == HOLD)) && flush) begin
      lat_nx = 1'b1;
    end
    if (done_nx) begin
      lat_nx = 1'b0;
    end
  end

  // Datapath registers: credits, hold slot, issue strobe, status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < n_add; k++) begin
        credit[k] <= cmax;
      end
      hold_vld   <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      flush_lat  <= 1'b0;
      out_val    <= '0;
      out_data   <= '0;
      flush_done <= 1'b0;
      cred_err   <= 1'b0;
    end else begin
      for (int k = 0; k < n_add; k++) begin
        credit[k] <= credit_nx[k];
      end
      out_val    <= iss_vec;
      flush_lat  <= lat_nx;
      flush_done <= done_nx;
      cred_err   <= cred_err | (|err_vec);
      if (issue) begin
        out_data <= sel_data;
      end
      if (capture) begin
        hold_vld  <= 1'b1;
        hold_addr <= pkt_addr;
        hold_data <= pkt_data;
      end else if (issue && (state == HOLD)) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule
